// File: rtl/if_stage_unit_pkg.sv
// rtl/if_stage_unit_pkg.sv - shared fetch-stage constants, fetch action type and its decoder
package if_stage_unit_pkg;

    // Pipeline datapath width (PC and instruction)
    localparam int PIPE_N = 32;

    // All-zero word decodes as sll r0,r0,0 and is what a squashed IF/ID holds
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Sequential fetch advances one 32-bit word
    localparam int PC_STEP = 4;

    // What the fetch stage does at the coming clock edge
    typedef enum logic [2:0] {
        FETCH_NORMAL      = 3'd0,  // advance PC, capture instruction
        FETCH_FREEZE      = 3'd1,  // hold PC and IF/ID
        FETCH_SQUASH_STEP = 3'd2,  // squash IF/ID, advance PC
        FETCH_SQUASH_HOLD = 3'd3,  // squash IF/ID, hold PC
        FETCH_REDIRECT    = 3'd4   // squash IF/ID, load branch target
    } fetch_op_e;

    // Priority: branch over flush over freeze over normal
    function automatic fetch_op_e fetch_decode(input logic branch_taken,
                                               input logic flush,
                                               input logic freeze);
        if (branch_taken) begin
            return FETCH_REDIRECT;
        end else if (flush) begin
            return freeze ? FETCH_SQUASH_HOLD : FETCH_SQUASH_STEP;
        end else if (freeze) begin
            return FETCH_FREEZE;
        end
        return FETCH_NORMAL;
    endfunction

endpackage

// File: rtl/if_stage_unit_if.sv
// rtl/if_stage_unit_if.sv - control, instruction memory and IF/ID signals of the fetch stage
interface if_stage_unit_if
    import if_stage_unit_pkg::*;
#(
    parameter int n = PIPE_N
);

    logic         freeze;
    logic         branch_taken;
    logic [n-1:0] branch_target;
    logic         flush;
    logic [n-1:0] instruction_in;
    logic [n-1:0] pc_out;
    logic [n-1:0] ifid_pc;
    logic [n-1:0] ifid_instruction;
    logic         ifid_valid;

    // Hazard unit, EX/ID and instruction memory side
    modport master (
        output freeze,
        output branch_taken,
        output branch_target,
        output flush,
        output instruction_in,
        input  pc_out,
        input  ifid_pc,
        input  ifid_instruction,
        input  ifid_valid
    );

    // Fetch stage side
    modport slave (
        input  freeze,
        input  branch_taken,
        input  branch_target,
        input  flush,
        input  instruction_in,
        output pc_out,
        output ifid_pc,
        output ifid_instruction,
        output ifid_valid
    );

endinterface

// File: rtl/if_stage_unit_pc_register.sv
// rtl/if_stage_unit_pc_register.sv - program counter register with load enable
module if_stage_unit_pc_register
    import if_stage_unit_pkg::*;
#(
    parameter int           n        = PIPE_N,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en_i,
    input  logic [n-1:0] load_value_i,
    output logic [n-1:0] pc_o
);

    logic [n-1:0] pc_q;
    logic [n-1:0] pc_d;

    // Next PC: take the load value when enabled, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_value_i;
        end
    end

    // PC state, returns to RESET_PC immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage_unit.sv
// rtl/if_stage_unit.sv - MIPS instruction fetch stage: PC, PC+4 and IF/ID register
module if_stage_unit
    import if_stage_unit_pkg::*;
#(
    parameter int           n        = PIPE_N,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    if_stage_unit_if.slave       bus
);

    logic [n-1:0] pc;
    logic [n-1:0] pc_plus4;
    logic         pc_load;
    logic [n-1:0] pc_load_value;
    fetch_op_e    fetch_op;

    logic [n-1:0] ifid_pc_q;
    logic [n-1:0] ifid_pc_d;
    logic [n-1:0] ifid_instruction_q;
    logic [n-1:0] ifid_instruction_d;
    logic         ifid_valid_q;
    logic         ifid_valid_d;

    if_stage_unit_pc_register #(
        .n        (n),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk          (clk),
        .rst          (rst),
        .load_en_i    (pc_load),
        .load_value_i (pc_load_value),
        .pc_o         (pc)
    );

    // Wraps silently modulo 2^n
    assign pc_plus4 = pc + n'(PC_STEP);

    assign fetch_op = fetch_decode(bus.branch_taken, bus.flush, bus.freeze);

    // PC update and IF/ID next state; instruction_in is only looked at on a normal fetch
    // so an undriven memory word during freeze or squash never reaches IF/ID
    always_comb begin
        pc_load            = 1'b0;
        pc_load_value      = pc_plus4;
        ifid_pc_d          = ifid_pc_q;
        ifid_instruction_d = ifid_instruction_q;
        ifid_valid_d       = ifid_valid_q;
        case (fetch_op)
            FETCH_NORMAL: begin
                pc_load            = 1'b1;
                ifid_pc_d          = pc_plus4;
                ifid_instruction_d = bus.instruction_in;
                ifid_valid_d       = 1'b1;
            end
            FETCH_FREEZE: begin
                pc_load = 1'b0;
            end
            FETCH_SQUASH_STEP: begin
                pc_load            = 1'b1;
                ifid_pc_d          = '0;
                ifid_instruction_d = n'(NOP_INSTR);
                ifid_valid_d       = 1'b0;
            end
            FETCH_SQUASH_HOLD: begin
                ifid_pc_d          = '0;
                ifid_instruction_d = n'(NOP_INSTR);
                ifid_valid_d       = 1'b0;
            end
            FETCH_REDIRECT: begin
                // Low two target bits are forced to zero to keep PC word-aligned
                pc_load            = 1'b1;
                pc_load_value      = bus.branch_target & ~n'(3);
                ifid_pc_d          = '0;
                ifid_instruction_d = n'(NOP_INSTR);
                ifid_valid_d       = 1'b0;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    // IF/ID pipeline register, cleared immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_pc_q          <= '0;
            ifid_instruction_q <= '0;
            ifid_valid_q       <= 1'b0;
        end else begin
            ifid_pc_q          <= ifid_pc_d;
            ifid_instruction_q <= ifid_instruction_d;
            ifid_valid_q       <= ifid_valid_d;
        end
    end

    assign bus.pc_out           = pc;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_instruction = ifid_instruction_q;
    assign bus.ifid_valid       = ifid_valid_q;

endmodule

// File: tb/tb_if_stage_unit.sv
// tb/tb_if_stage_unit.sv - directed self-checking bench for if_stage_unit
module tb_if_stage_unit;

    logic clk;
    logic rst;
    logic force_x;

    logic [31:0] mem [0:7];

    int n_compared;
    int n_mismatched;

    if_stage_unit_if #(.n(32)) bus ();
    if_stage_unit_if #(.n(32)) bus_w ();

    if_stage_unit #(
        .n        (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    if_stage_unit #(
        .n        (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    assign bus.instruction_in   = force_x ? 32'hxxxx_xxxx : mem[bus.pc_out[4:2]];
    assign bus_w.instruction_in = mem[bus_w.pc_out[4:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic fz, input logic br, input logic [31:0] tgt, input logic fl);
        bus.freeze        = fz;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.flush         = fl;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        mem[0] = 32'h0000_0800;
        mem[1] = 32'h0003_2000;
        mem[2] = 32'h2008_0005;
        mem[3] = 32'h0109_5020;
        mem[4] = 32'h8d0a_0010;
        mem[5] = 32'had0b_0004;
        mem[6] = 32'h1000_fffe;
        mem[7] = 32'h0800_0003;
        force_x = 1'b0;
        rst     = 1'b0;
        set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
        bus_w.freeze        = 1'b0;
        bus_w.branch_taken  = 1'b0;
        bus_w.branch_target = 32'h0;
        bus_w.flush         = 1'b0;

        // Reset held for two edges
        step();
        step();
        chk("rst_pc",        bus.pc_out,           32'h0);
        chk("rst_ifid_pc",   bus.ifid_pc,          32'h0);
        chk("rst_ifid_ins",  bus.ifid_instruction, 32'h0);
        chk("rst_valid",     32'(bus.ifid_valid),  32'h0);
        chk("rst_wrap_pc",   bus_w.pc_out,         32'hFFFF_FFFC);
        rst = 1'b1;

        // Edge 1
        step();
        chk("e1_ins",        bus.ifid_instruction, 32'h0000_0800);
        chk("e1_ifid_pc",    bus.ifid_pc,          32'h4);
        chk("e1_valid",      32'(bus.ifid_valid),  32'h1);
        chk("e1_pc",         bus.pc_out,           32'h4);
        chk("wrap_pc",       bus_w.pc_out,         32'h0);
        chk("wrap_ifid_pc",  bus_w.ifid_pc,        32'h0);
        chk("wrap_valid",    32'(bus_w.ifid_valid), 32'h1);
        chk("wrap_ins",      bus_w.ifid_instruction, 32'h0800_0003);

        // Edge 2
        step();
        chk("e2_ins",        bus.ifid_instruction, 32'h0003_2000);
        chk("e2_ifid_pc",    bus.ifid_pc,          32'h8);
        chk("e2_pc",         bus.pc_out,           32'h8);

        // Freeze three cycles with undriven memory
        set_ctl(1'b1, 1'b0, 32'h0, 1'b0);
        force_x = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_pc",      bus.pc_out,           32'h8);
            chk("frz_ins",     bus.ifid_instruction, 32'h0003_2000);
            chk("frz_ifid_pc", bus.ifid_pc,          32'h8);
            chk("frz_valid",   32'(bus.ifid_valid),  32'h1);
            chk("frz_xfree",   32'($isunknown({bus.ifid_instruction, bus.ifid_pc, bus.ifid_valid})), 32'h0);
        end
        set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
        force_x = 1'b0;
        step();
        chk("unfrz_pc",      bus.pc_out,           32'hC);
        chk("unfrz_ins",     bus.ifid_instruction, 32'h2008_0005);
        chk("unfrz_ifid_pc", bus.ifid_pc,          32'hC);

        // Branch beats freeze, target low bits dropped
        set_ctl(1'b1, 1'b1, 32'h0000_0013, 1'b0);
        step();
        chk("br_pc",         bus.pc_out,           32'h10);
        chk("br_valid",      32'(bus.ifid_valid),  32'h0);
        chk("br_ins",        bus.ifid_instruction, 32'h0);
        chk("br_ifid_pc",    bus.ifid_pc,          32'h0);
        set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("abr_ins",       bus.ifid_instruction, 32'h8d0a_0010);
        chk("abr_ifid_pc",   bus.ifid_pc,          32'h14);
        chk("abr_valid",     32'(bus.ifid_valid),  32'h1);
        chk("abr_pc",        bus.pc_out,           32'h14);

        // Flush with freeze holds PC, flush alone steps PC
        set_ctl(1'b1, 1'b0, 32'h0, 1'b1);
        step();
        chk("flfz_pc",       bus.pc_out,           32'h14);
        chk("flfz_valid",    32'(bus.ifid_valid),  32'h0);
        chk("flfz_ins",      bus.ifid_instruction, 32'h0);
        set_ctl(1'b0, 1'b0, 32'h0, 1'b1);
        step();
        chk("fl_pc",         bus.pc_out,           32'h18);
        chk("fl_valid",      32'(bus.ifid_valid),  32'h0);

        // Freeze after squash keeps the bubble
        set_ctl(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        chk("sqfz_pc",       bus.pc_out,           32'h18);
        chk("sqfz_valid",    32'(bus.ifid_valid),  32'h0);
        set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        chk("n6_ins",        bus.ifid_instruction, 32'h1000_fffe);
        chk("n6_ifid_pc",    bus.ifid_pc,          32'h1C);
        chk("n6_valid",      32'(bus.ifid_valid),  32'h1);
        step();
        chk("n7_pc",         bus.pc_out,           32'h20);
        chk("n7_ins",        bus.ifid_instruction, 32'h0800_0003);

        // Async reset mid high phase with a redirect pending
        set_ctl(1'b0, 1'b1, 32'h0000_0040, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_clk_high",   32'(clk),             32'h1);
        chk("ar_pc",         bus.pc_out,           32'h0);
        chk("ar_valid",      32'(bus.ifid_valid),  32'h0);
        chk("ar_ins",        bus.ifid_instruction, 32'h0);
        chk("ar_ifid_pc",    bus.ifid_pc,          32'h0);
        step();
        chk("ar_hold_pc",    bus.pc_out,           32'h0);
        set_ctl(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        chk("post_pc",       bus.pc_out,           32'h4);
        chk("post_ins",      bus.ifid_instruction, 32'h0000_0800);
        chk("post_valid",    32'(bus.ifid_valid),  32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
